dest_domain: RTL and testbench
==============================

// Module: dest_domain
// PURPOSE
//  Destination-side receiver of the toggle-based CDC link driven by src_domain.
//  Synchronises the src2dest_load toggle into CLK and detects each toggle as one
//  transfer event. Captures src2dest_data on each event and presents it through a
//  valid/ready output register. Returns a toggle acknowledge and keeps a
//  transfer counter and a sticky overflow flag.
// PARAMETERS
//  DATAWIDTH   8   width of src2dest_data / dest_data_out
//  SYNC_STAGES 2   flops in the toggle synchroniser (legal >= 2)
//  CNT_WIDTH   16  width of dest_xfer_cnt (wraps)
// PORTS
//  CLK              in   1          destination clock
//  RSTn             in   1          reset, asynchronous, active-low
//  src2dest_data    in   DATAWIDTH  source-domain data; stable while the toggle crosses
//  src2dest_load    in   1          source-domain toggle; each level change = 1 transfer
//  dest_data_ready  in   1          consumer accepts dest_data_out when high with valid
//  dest_overflow_clr in  1          synchronous clear of dest_overflow
//  dest_data_out    out  DATAWIDTH  captured data word
//  dest_data_valid  out  1          dest_data_out holds an unconsumed word
//  dest2src_ack     out  1          toggle to source; flips once per captured transfer
//  dest_overflow    out  1          sticky: a word was overwritten before being accepted
//  dest_xfer_cnt    out  CNT_WIDTH  number of captured transfers, modulo 2^CNT_WIDTH
// BEHAVIOUR
//  Reset: sync chain, load_prev, dest_data_out, dest_data_valid, dest2src_ack,
//   dest_overflow, dest_xfer_cnt all 0. Warm-up counter loaded with SYNC_STAGES+1.
//  Synchroniser: load_sync[0] <= src2dest_load; load_sync[i] <= load_sync[i-1].
//   Only load_sync[0] samples the async input. No other logic uses src2dest_load.
//  Event: evt = (load_sync[SYNC_STAGES-1] ^ load_prev) & (warm-up == 0).
//   load_prev <= load_sync[SYNC_STAGES-1] every cycle, including during warm-up.
//  Warm-up: counts down to 0 after reset, one per cycle. Toggle level differences
//   seen while it is non-zero are absorbed, not reported. This prevents a spurious
//   event when dest resets while source toggle = 1.
//  Latency: toggle changes before CLK edge k. Then load_sync[0] = new level after
//   edge k, evt is high between edges k+SYNC_STAGES-1 and k+SYNC_STAGES, and
//   dest_data_valid = 1 after edge k+SYNC_STAGES. For SYNC_STAGES = 2: 3 edges.
//  Capture on evt: dest_data_out <= src2dest_data; dest_data_valid <= 1;
//   dest2src_ack <= ~dest2src_ack; dest_xfer_cnt <= dest_xfer_cnt + 1 (wraps).
//  Accept: dest_data_valid & dest_data_ready & ~evt -> dest_data_valid <= 0.
//  Simultaneous cases:
//   - evt & valid & ready: old word consumed, new word loaded, valid stays 1,
//     no overflow.
//   - evt & valid & ~ready: new word overwrites (latest wins), valid stays 1,
//     dest_overflow <= 1.
//   - overflow set and dest_overflow_clr in the same cycle: set wins.
//  Source spacing: consecutive source toggles must be >= SYNC_STAGES+2 CLK cycles
//   apart, and src2dest_data must not change during that window. Closer spacing
//   is a protocol violation; behaviour is undefined (events may merge).
//  Mid-operation reset: all state returns to reset values; a word in flight is
//   lost; warm-up is re-armed.
// TESTING
//  1 Reset, src toggle 0->1 with data 8'hA5 -> after 3 CLK edges: valid = 1,
//    dest_data_out = A5, ack = 1, cnt = 1; ready = 1 -> valid = 0 next edge.
//  2 ready held 0, two transfers 8'h11 then 8'h22, spaced 4 cycles ->
//    out = 22, valid = 1, overflow = 1, cnt = 2; clr pulse -> overflow = 0.
//  3 ready = 1 in the same cycle as the second event -> out = 22, valid stays 1,
//    overflow = 0.
//  4 Source toggle held at 1, pulse RSTn on dest only -> no event, valid = 0,
//    cnt = 0 after warm-up; next toggle 1->0 -> exactly one event.
//  5 Drive 2^CNT_WIDTH+3 transfers (CNT_WIDTH = 4 build) -> cnt = 3; ack parity
//    equals transfer count parity.
//  6 Assert RSTn low with valid = 1 and a toggle mid-sync -> all outputs 0 after
//    reset; no event is produced for that toggle.

Source files
------------

// File: rtl/dest_domain.sv
// rtl/dest_domain.sv - destination-side receiver of the toggle-based CDC link
//
// Purpose:
//   Synchronises the source toggle src2dest_load into CLK. Each level change
//   of the toggle is one transfer event. On an event the module captures
//   src2dest_data into a valid/ready output register and flips the
//   acknowledge toggle. It also counts captured transfers and keeps a sticky
//   overflow flag.
//
// Ports:
//   CLK               in   destination clock
//   RSTn              in   asynchronous active-low reset
//   src2dest_data     in   source data word, stable while the toggle crosses
//   src2dest_load     in   source toggle; each level change is one transfer
//   dest_data_ready   in   consumer accepts dest_data_out while valid is high
//   dest_overflow_clr in   synchronous clear of dest_overflow
//   dest_data_out     out  captured data word
//   dest_data_valid   out  dest_data_out holds an unconsumed word
//   dest2src_ack      out  acknowledge toggle; flips once per captured transfer
//   dest_overflow     out  sticky: a word was overwritten before it was accepted
//   dest_xfer_cnt     out  captured transfer count, wraps

module dest_domain #(
   parameter int DATAWIDTH   = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 CLK,
   input  logic                 RSTn,
   input  logic [DATAWIDTH-1:0] src2dest_data,
   input  logic                 src2dest_load,
   input  logic                 dest_data_ready,
   input  logic                 dest_overflow_clr,
   output logic [DATAWIDTH-1:0] dest_data_out,
   output logic                 dest_data_valid,
   output logic                 dest2src_ack,
   output logic                 dest_overflow,
   output logic [CNT_WIDTH-1:0] dest_xfer_cnt
);

   localparam int              WU_W    = $clog2(SYNC_STAGES + 2);
   localparam logic [WU_W-1:0] WU_INIT = WU_W'(SYNC_STAGES + 1);

   logic [SYNC_STAGES-1:0] load_sync;
   logic                   load_prev;
   logic [WU_W-1:0]        warmup;
   logic                   evt;
   logic                   accept;
   logic                   ovf_set;

   // Only load_sync[0] samples the asynchronous toggle.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         load_sync <= '0;
      end else begin
         load_sync <= {load_sync[SYNC_STAGES-2:0], src2dest_load};
      end
   end

   // load_prev tracks the synchronised level even during warm-up. Any
   // difference seen during warm-up is therefore absorbed. This covers the
   // case where dest resets while the source toggle is already high.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         load_prev <= 1'b0;
         warmup    <= WU_INIT;
      end else begin
         load_prev <= load_sync[SYNC_STAGES-1];
         if (warmup != '0) begin
            warmup <= warmup - 1'b1;
         end
      end
   end

   assign evt     = (load_sync[SYNC_STAGES-1] ^ load_prev) & (warmup == '0);
   // A word accepted in the same cycle as an event is replaced, so valid stays 1.
   assign accept  = dest_data_valid & dest_data_ready & ~evt;
   assign ovf_set = evt & dest_data_valid & ~dest_data_ready;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         dest_data_out   <= '0;
         dest_data_valid <= 1'b0;
         dest2src_ack    <= 1'b0;
         dest_xfer_cnt   <= '0;
      end else if (evt) begin
         dest_data_out   <= src2dest_data;
         dest_data_valid <= 1'b1;
         dest2src_ack    <= ~dest2src_ack;
         dest_xfer_cnt   <= dest_xfer_cnt + 1'b1;
      end else if (accept) begin
         dest_data_valid <= 1'b0;
      end
   end

   // Setting the flag takes priority over a clear in the same cycle.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         dest_overflow <= 1'b0;
      end else if (ovf_set) begin
         dest_overflow <= 1'b1;
      end else if (dest_overflow_clr) begin
         dest_overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dest_domain.sv
// tb/tb_dest_domain.sv - self-checking bench for dest_domain
module tb_dest_domain;

   localparam int DW = 8;
   localparam int SS = 2;
   localparam int CW = 4;

   logic          CLK = 1'b0;
   logic          RSTn = 1'b0;
   logic [DW-1:0] src2dest_data = '0;
   logic          src2dest_load = 1'b0;
   logic          dest_data_ready = 1'b0;
   logic          dest_overflow_clr = 1'b0;
   logic [DW-1:0] dest_data_out;
   logic          dest_data_valid;
   logic          dest2src_ack;
   logic          dest_overflow;
   logic [CW-1:0] dest_xfer_cnt;

   dest_domain #(.DATAWIDTH(DW), .SYNC_STAGES(SS), .CNT_WIDTH(CW)) dut (
      .CLK(CLK),
      .RSTn(RSTn),
      .src2dest_data(src2dest_data),
      .src2dest_load(src2dest_load),
      .dest_data_ready(dest_data_ready),
      .dest_overflow_clr(dest_overflow_clr),
      .dest_data_out(dest_data_out),
      .dest_data_valid(dest_data_valid),
      .dest2src_ack(dest2src_ack),
      .dest_overflow(dest_overflow),
      .dest_xfer_cnt(dest_xfer_cnt)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: each toggle becomes a scheduled capture at a known
   // edge number. The word is captured there, or it is dropped on reset.
   typedef struct {
      int          edge_no;
      logic [DW-1:0] data;
   } ev_t;
   ev_t           evq[$];
   int            edge_cnt = 0;
   logic [DW-1:0] m_data = '0;
   logic          m_valid = 1'b0;
   logic          m_ack = 1'b0;
   logic          m_ovf = 1'b0;
   int            m_cnt = 0;

   task automatic model_step();
      ev_t e;
      logic set;
      if (!RSTn) begin
         m_data = '0; m_valid = 0; m_ack = 0; m_ovf = 0; m_cnt = 0;
         evq.delete();
      end else begin
         edge_cnt++;
         set = 0;
         if (evq.size() > 0 && evq[0].edge_no == edge_cnt) begin
            e = evq.pop_front();
            if (m_valid && !dest_data_ready) set = 1;
            m_data  = e.data;
            m_valid = 1;
            m_ack   = ~m_ack;
            m_cnt   = (m_cnt + 1) % (1 << CW);
         end else if (m_valid && dest_data_ready) begin
            m_valid = 0;
         end
         if (set) m_ovf = 1;
         else if (dest_overflow_clr) m_ovf = 0;
      end
   endtask

   initial begin
      forever begin
         @(posedge CLK or negedge RSTn);
         model_step();
      end
   end

   initial begin
      forever begin
         @(negedge CLK);
         check("cyc_data",  32'(dest_data_out),   32'(m_data));
         check("cyc_valid", 32'(dest_data_valid), 32'(m_valid));
         check("cyc_ack",   32'(dest2src_ack),    32'(m_ack));
         check("cyc_ovf",   32'(dest_overflow),   32'(m_ovf));
         check("cyc_cnt",   32'(dest_xfer_cnt),   32'(m_cnt));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // The toggle is applied after edge edge_cnt, so it is sampled at edge
   // edge_cnt+1. The capture lands SS edges after that.
   task automatic xfer(input logic [DW-1:0] d);
      ev_t e;
      src2dest_data = d;
      src2dest_load = ~src2dest_load;
      e.edge_no = edge_cnt + 1 + SS;
      e.data    = d;
      evq.push_back(e);
   endtask

   task automatic do_reset();
      RSTn = 1'b0;
      tick(2);
      RSTn = 1'b1;
      tick(SS + 3);
   endtask

   initial begin
      tick(1);
      check("rst_valid", 32'(dest_data_valid), 32'h0);
      check("rst_cnt",   32'(dest_xfer_cnt),   32'h0);
      RSTn = 1'b1;
      tick(SS + 3);

      // Test 1: single transfer, three-edge latency, then accept.
      xfer(8'hA5);
      tick(2);
      check("t1_not_yet", 32'(dest_data_valid), 32'h0);
      tick(1);
      check("t1_valid", 32'(dest_data_valid), 32'h1);
      check("t1_data",  32'(dest_data_out),   32'hA5);
      check("t1_ack",   32'(dest2src_ack),    32'h1);
      check("t1_cnt",   32'(dest_xfer_cnt),   32'h1);
      dest_data_ready = 1'b1;
      tick(1);
      check("t1_accept", 32'(dest_data_valid), 32'h0);
      dest_data_ready = 1'b0;

      // Test 2: overwrite while not ready sets overflow; clear drops it.
      do_reset();
      xfer(8'h11);
      tick(SS + 2);
      xfer(8'h22);
      tick(SS + 2);
      check("t2_data",  32'(dest_data_out),   32'h22);
      check("t2_valid", 32'(dest_data_valid), 32'h1);
      check("t2_ovf",   32'(dest_overflow),   32'h1);
      check("t2_cnt",   32'(dest_xfer_cnt),   32'h2);
      dest_overflow_clr = 1'b1;
      tick(1);
      dest_overflow_clr = 1'b0;
      check("t2_clr", 32'(dest_overflow), 32'h0);

      // Test 3: ready is high exactly on the second capture edge.
      do_reset();
      xfer(8'h11);
      tick(SS + 2);
      xfer(8'h22);
      tick(SS);
      dest_data_ready = 1'b1;
      tick(1);
      dest_data_ready = 1'b0;
      check("t3_data",  32'(dest_data_out),   32'h22);
      check("t3_valid", 32'(dest_data_valid), 32'h1);
      check("t3_ovf",   32'(dest_overflow),   32'h0);
      tick(2);

      // Test 4: reset dest while the source toggle is held at 1.
      RSTn = 1'b0;
      src2dest_load = 1'b1;
      tick(2);
      RSTn = 1'b1;
      tick(SS + 4);
      check("t4_valid", 32'(dest_data_valid), 32'h0);
      check("t4_cnt",   32'(dest_xfer_cnt),   32'h0);
      xfer(8'h3C);
      tick(SS + 3);
      check("t4_one_evt", 32'(dest_xfer_cnt), 32'h1);
      check("t4_data",    32'(dest_data_out), 32'h3C);

      // Test 5: counter wrap over 2^CW + 3 transfers.
      do_reset();
      dest_data_ready = 1'b1;
      for (int i = 0; i < (1 << CW) + 3; i++) begin
         xfer(8'(i * 7 + 1));
         tick(SS + 2);
      end
      tick(2);
      check("t5_cnt", 32'(dest_xfer_cnt), 32'h3);
      check("t5_ack", 32'(dest2src_ack),  32'h1);
      dest_data_ready = 1'b0;

      // Test 6: reset with a valid word and a toggle still in the synchroniser.
      do_reset();
      xfer(8'h5A);
      tick(SS + 2);
      xfer(8'h6B);
      tick(1);
      RSTn = 1'b0;
      #1;
      check("t6_rst_valid", 32'(dest_data_valid), 32'h0);
      check("t6_rst_data",  32'(dest_data_out),   32'h0);
      check("t6_rst_ack",   32'(dest2src_ack),    32'h0);
      check("t6_rst_cnt",   32'(dest_xfer_cnt),   32'h0);
      tick(2);
      RSTn = 1'b1;
      tick(SS + 6);
      check("t6_no_evt", 32'(dest_xfer_cnt),   32'h0);
      check("t6_valid",  32'(dest_data_valid), 32'h0);

      // Randomised traffic with random ready and clear activity.
      for (int i = 0; i < 200; i++) begin
         int gap;
         xfer(8'($urandom));
         gap = $urandom_range(SS + 2, SS + 6);
         for (int j = 0; j < gap; j++) begin
            dest_data_ready   = 1'($urandom_range(0, 1));
            dest_overflow_clr = ($urandom_range(0, 7) == 0);
            tick(1);
         end
      end
      dest_data_ready   = 1'b0;
      dest_overflow_clr = 1'b0;
      tick(4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
